fifo_uart_tx: RTL
=================

# fifo_uart_tx

Read-side consumer for the synchronous FIFO. Drains bytes from the FIFO read interface (`rd_en`/`dout`/`empty`) and serializes each one as an 8N1 UART frame on `serial_out`. Sits between the FIFO and the board TX pin, so upstream logic only writes the FIFO and never waits on baud timing.

## Interface
- `CLOCK_FREQ`, 125_000_000: clock frequency in Hz.
- `BAUD_RATE`, 115_200: line rate in bits per second.
- `DATA_WIDTH`, 8: FIFO word width; only bits [7:0] are transmitted.
- `clk` in 1: single clock; all logic is in this domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `fifo_empty` in 1: FIFO `empty` flag.
- `fifo_dout` in DATA_WIDTH: FIFO `dout`. Valid in the cycle after the edge that sampled `fifo_rd_en`=1.
- `fifo_rd_en` out 1: FIFO `rd_en`.
- `serial_out` out 1: UART TX line. Idles high.
- `busy` out 1: high from LOAD through the end of STOP.
- `tx_count` out 16: number of completed frames. Wraps at 65535 to 0.

## Operation
- `SYMBOL_EDGE_TIME` = CLOCK_FREQ / BAUD_RATE, using integer division. The baud counter width is clog2(SYMBOL_EDGE_TIME).
- The FSM has states IDLE, LOAD, START, DATA, STOP.
- **IDLE**
  - `fifo_rd_en` = !fifo_empty, driven combinationally from state.
  - If `fifo_empty`=0, go to LOAD. Otherwise stay in IDLE.
- **LOAD** (exactly 1 cycle)
  - Shift register <= fifo_dout[7:0].
  - Bit index <= 0, baud counter <= 0.
  - Go to START.
- **START**: `serial_out`=0 for SYMBOL_EDGE_TIME cycles, then go to DATA.
- **DATA**
  - `serial_out` = shift register bit 0, LSB first. Each bit is held for SYMBOL_EDGE_TIME cycles.
  - When a bit ends: shift right and increment the index.
  - After bit 7, go to STOP.
- **STOP**: `serial_out`=1 for SYMBOL_EDGE_TIME cycles. On the final cycle, increment `tx_count` and go to IDLE.
- `fifo_rd_en` is never high when `fifo_empty`=1 and never high outside IDLE. Each frame pops exactly one entry.
- Bits [DATA_WIDTH-1:8] of `fifo_dout` are ignored.

## Timing
- Reset values: `serial_out`=1, `fifo_rd_en`=0, `busy`=0, `tx_count`=0, state=IDLE. Reset takes effect immediately on `rst_n` falling, without waiting for a clock edge.
- `serial_out` is a register, so it changes one cycle after the state change that causes it.
- Latency, with cycle T being the IDLE cycle where `fifo_empty`=0:
  - `fifo_rd_en`=1 in T.
  - LOAD in T+1.
  - `serial_out` falls at the edge ending T+1.
- Each frame is exactly 10×SYMBOL_EDGE_TIME cycles long.
- Back-to-back bytes: the minimum idle-high gap between a stop bit and the next start bit is exactly 2 cycles (IDLE + LOAD).
- `fifo_empty` rising during a frame has no effect. `fifo_empty` is sampled only in IDLE.
- Reset mid-frame:
  - `serial_out` returns high at once and the byte in flight is lost.
  - `tx_count` does not count the aborted frame.
  - The FIFO entry already popped is not restored.

## Structure
- Shared package `uart_pkg` holds:
  - the FSM state encoding (3-bit, 5 states);
  - the `SYMBOL_EDGE_TIME` and counter-width constant functions, which the future `uart_rx` will also use.
- One sub-module, `uart_baud_tick`:
  - a counter parameterized by SYMBOL_EDGE_TIME;
  - inputs `clk`, `rst_n`, `clear`;
  - output `tick`, high on the last cycle of each bit period.
- The top level holds the FSM, shift register, bit index and `tx_count`.

## Test plan
Benches use CLOCK_FREQ=1000 and BAUD_RATE=100, so SYMBOL_EDGE_TIME=10.

- **Reset, empty FIFO, 50 cycles**
  - `serial_out`=1, `fifo_rd_en`=0, `busy`=0 and `tx_count`=0 throughout.
- **Single byte 8'hA5**
  - `fifo_rd_en` is high for 1 cycle.
  - The line reads 0,1,0,1,0,0,1,0,1,1, with each level held 10 cycles.
  - `tx_count`=1 afterwards.
- **Eight bytes written back-to-back (8'h00..8'h07, fill to full)**
  - 8 frames come out in order, each 100 cycles long.
  - Gaps between frames are exactly 2 high cycles.
  - `fifo_empty`=1 and `tx_count`=8 at the end.
- **Underflow guard**
  - Hold `fifo_empty`=1 and pulse `fifo_dout` to random values.
  - `fifo_rd_en` never asserts and `serial_out` stays 1.
- **Reset mid-frame**
  - Assert `rst_n`=0 at cycle 35 of a frame for byte 8'h3C.
  - `serial_out`=1 within the same cycle and `tx_count` stays 0.
  - After release with the FIFO non-empty, the next byte transmits cleanly.
- **Count wrap**
  - Force `tx_count` to 65535, then send one byte.
  - `tx_count`=0.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and baud timing helpers
package uart_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;

  function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

  // Clamped to 1 so a degenerate one-cycle bit period still yields a legal counter.
  function automatic int baud_cnt_width(input int edge_time);
    return (edge_time > 1) ? $clog2(edge_time) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - bit-period counter, tick on the last cycle of each period
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int SYMBOL_EDGE_TIME = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = baud_cnt_width(SYMBOL_EDGE_TIME);
  localparam logic [CW-1:0] LAST = CW'(SYMBOL_EDGE_TIME - 1);

  logic [CW-1:0] cnt;

  assign tick = !clear && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - drains a FIFO and serializes each byte as an 8N1 UART frame
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic                  serial_out,
  output logic                  busy,
  output logic [15:0]           tx_count
);

  localparam int SET = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);

  logic [2:0] state;
  logic [7:0] shift_reg;
  logic [2:0] bit_idx;
  logic       tick;
  logic       baud_clear;

  // Bit period restarts from zero on entry to START, so hold the counter clear until then.
  assign baud_clear = (state == ST_IDLE) || (state == ST_LOAD);
  assign fifo_rd_en = rst_n && (state == ST_IDLE) && !fifo_empty;
  assign busy       = (state != ST_IDLE);

  uart_baud_tick #(
    .SYMBOL_EDGE_TIME(SET)
  ) u_baud (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(baud_clear),
    .tick (tick)
  );

  // serial_out is loaded with the level of the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      shift_reg  <= '0;
      bit_idx    <= '0;
      serial_out <= 1'b1;
      tx_count   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          serial_out <= 1'b1;
          if (!fifo_empty) state <= ST_LOAD;
        end
        ST_LOAD: begin
          shift_reg  <= fifo_dout[7:0];
          bit_idx    <= '0;
          serial_out <= 1'b0;
          state      <= ST_START;
        end
        ST_START: begin
          if (tick) begin
            serial_out <= shift_reg[0];
            state      <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (tick) begin
            shift_reg <= {1'b0, shift_reg[7:1]};
            bit_idx   <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              serial_out <= 1'b1;
              state      <= ST_STOP;
            end else begin
              serial_out <= shift_reg[1];
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            tx_count <= tx_count + 16'd1;
            state    <= ST_IDLE;
          end
        end
        default: begin
          serial_out <= 1'b1;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
